// File: rtl/alu_ctrl_mdu_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_mdu_pkg : ALU control codes, funct codes and MDU FSM states
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_ctrl_mdu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;
   localparam logic [3:0] ALU_NOP  = 4'b1111;

   localparam logic [1:0] ALUOP_MEM   = 2'b00;
   localparam logic [1:0] ALUOP_BEQ   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [5:0] FUNCT_ADD   = 6'b100000;
   localparam logic [5:0] FUNCT_SUB   = 6'b100010;
   localparam logic [5:0] FUNCT_AND   = 6'b100100;
   localparam logic [5:0] FUNCT_OR    = 6'b100101;
   localparam logic [5:0] FUNCT_SLT   = 6'b101010;
   localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_MUL  = 2'd1,
      MDU_DIV  = 2'd2,
      MDU_FIN  = 2'd3
   } mdu_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_mdu_mdu_iter.sv
// ---------------------------------------------------------------------------
// mdu_iter : iterative shift-add multiplier / restoring divider with HI/LO
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mdu_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_div,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   import alu_ctrl_mdu_pkg::*;

   mdu_state_t state, state_nxt;

   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   dvsr;
   logic               div_op;
   logic               neg_q;
   logic               neg_r;
   logic               div_zero;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH-1:0]   mul_addend;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_part;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic [WIDTH-1:0]   fin_hi, fin_lo;

   always_ff @(posedge clk) begin
      if (reset) state <= MDU_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = (state != MDU_IDLE);
      done      = 1'b0;
      case (state)
         MDU_IDLE: if (start) state_nxt = is_div ? MDU_DIV : MDU_MUL;
         MDU_MUL,
         MDU_DIV:  if (cnt == CNT_W'(1)) state_nxt = MDU_FIN;
         MDU_FIN: begin
            done      = 1'b1;
            state_nxt = MDU_IDLE;
         end
         default:  state_nxt = MDU_IDLE;
      endcase
   end

   always_comb begin
      a_neg = is_signed & op_a[WIDTH-1];
      b_neg = is_signed & op_b[WIDTH-1];
      a_mag = a_neg ? -op_a : op_a;
      b_mag = b_neg ? -op_b : op_b;

      // Multiply: multiplier sits in acc low half and shifts out LSB first.
      mul_addend = acc[0] ? dvsr : {WIDTH{1'b0}};
      mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
      mul_next   = {mul_sum, acc[WIDTH-1:1]};

      // Divide: remainder in upper half, dividend/quotient shifting left below it.
      div_part = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff = div_part - {1'b0, dvsr};
      div_next = div_diff[WIDTH] ? {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

      prod_fix = neg_q ? -acc : acc;
      quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

      // A zero divisor leaves the dividend as remainder; only LO needs forcing.
      fin_hi = div_op ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
      fin_lo = div_op ? (div_zero ? {WIDTH{1'b1}} : quo_fix) : prod_fix[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         acc      <= '0;
         dvsr     <= '0;
         div_op   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         case (state)
            MDU_IDLE: begin
               if (start) begin
                  cnt      <= CNT_W'(WIDTH);
                  acc      <= {{WIDTH{1'b0}}, a_mag};
                  dvsr     <= b_mag;
                  div_op   <= is_div;
                  neg_q    <= a_neg ^ b_neg;
                  neg_r    <= a_neg;
                  div_zero <= (op_b == '0);
               end
            end
            MDU_MUL: begin
               acc <= mul_next;
               cnt <= cnt - CNT_W'(1);
            end
            MDU_DIV: begin
               acc <= div_next;
               cnt <= cnt - CNT_W'(1);
            end
            MDU_FIN: begin
               hi <= fin_hi;
               lo <= fin_lo;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_ctrl_mdu.sv
// ---------------------------------------------------------------------------
// alu_ctrl_mdu : ALU control decode plus iterative MDU with HI/LO and stall
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_ctrl_mdu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [3:0]       alu_ctrl,
   output logic             use_mdu_res,
   output logic [WIDTH-1:0] mdu_res,
   output logic             busy,
   output logic             done,
   output logic             illegal
);
   import alu_ctrl_mdu_pkg::*;

   logic             is_muldiv;
   logic             is_div;
   logic             is_signed;
   logic             sel_hi;
   logic             core_busy;
   logic             start;
   logic [WIDTH-1:0] hi, lo;

   always_comb begin
      alu_ctrl    = ALU_NOP;
      illegal     = 1'b0;
      use_mdu_res = 1'b0;
      is_muldiv   = 1'b0;
      is_div      = 1'b0;
      is_signed   = 1'b0;
      sel_hi      = 1'b0;
      case (alu_op)
         ALUOP_MEM:   alu_ctrl = ALU_ADD;
         ALUOP_BEQ:   alu_ctrl = ALU_SUB;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD:   alu_ctrl = ALU_ADD;
               FUNCT_SUB:   alu_ctrl = ALU_SUB;
               FUNCT_AND:   alu_ctrl = ALU_AND;
               FUNCT_OR:    alu_ctrl = ALU_OR;
               FUNCT_SLT:   alu_ctrl = ALU_SLT;
               FUNCT_SLTU:  alu_ctrl = ALU_SLTU;
               FUNCT_MULT:  begin is_muldiv = 1'b1; is_signed = 1'b1; end
               FUNCT_MULTU: is_muldiv = 1'b1;
               FUNCT_DIV:   begin is_muldiv = 1'b1; is_div = 1'b1; is_signed = 1'b1; end
               FUNCT_DIVU:  begin is_muldiv = 1'b1; is_div = 1'b1; end
               FUNCT_MFHI:  begin use_mdu_res = 1'b1; sel_hi = 1'b1; end
               FUNCT_MFLO:  use_mdu_res = 1'b1;
               default:     illegal = 1'b1;
            endcase
         end
         default:     illegal = 1'b1;
      endcase
   end

   // The issuing mult/div stalls in its accept cycle too, so the stall is seamless.
   assign start   = valid_in & is_muldiv & ~core_busy;
   assign busy    = core_busy | (valid_in & is_muldiv);
   assign mdu_res = sel_hi ? hi : lo;

   mdu_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_mdu_iter (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .is_div    (is_div),
      .is_signed (is_signed),
      .op_a      (op_a),
      .op_b      (op_b),
      .busy      (core_busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_mdu.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_mdu : randomized self-checking bench for alu_ctrl_mdu
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_ctrl_mdu;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam int         LAT     = 32;   // edges from accept edge to done

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  alu_op;
   logic [5:0]  funct;
   logic        valid_in;
   logic [31:0] op_a, op_b;
   logic [3:0]  alu_ctrl;
   logic        use_mdu_res;
   logic [31:0] mdu_res;
   logic        busy, done, illegal;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   alu_ctrl_mdu #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .alu_op      (alu_op),
      .funct       (funct),
      .valid_in    (valid_in),
      .op_a        (op_a),
      .op_b        (op_b),
      .alu_ctrl    (alu_ctrl),
      .use_mdu_res (use_mdu_res),
      .mdu_res     (mdu_res),
      .busy        (busy),
      .done        (done),
      .illegal     (illegal)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // {alu_ctrl, illegal, use_mdu_res} from the decode table
   function automatic logic [5:0] model_decode(input logic [1:0] op, input logic [5:0] f);
      logic [5:0] r;
      r = {4'hF, 1'b1, 1'b0};
      if (op == 2'b00) r = {4'h2, 2'b00};
      else if (op == 2'b01) r = {4'h6, 2'b00};
      else if (op == 2'b10) begin
         case (f)
            6'b100000: r = {4'h2, 2'b00};
            6'b100010: r = {4'h6, 2'b00};
            6'b100100: r = {4'h0, 2'b00};
            6'b100101: r = {4'h1, 2'b00};
            6'b101010: r = {4'h7, 2'b00};
            6'b101011: r = {4'h8, 2'b00};
            F_MULT, F_MULTU, F_DIV, F_DIVU: r = {4'hF, 2'b00};
            F_MFHI, F_MFLO:                 r = {4'hF, 2'b01};
            default:                        r = {4'hF, 2'b10};
         endcase
      end
      return r;
   endfunction

   task automatic model_mdu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] h, output logic [31:0] l);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      h = '0; l = '0;
      case (f)
         F_MULT:  begin p = sa * sb;                    h = p[63:32]; l = p[31:0]; end
         F_MULTU: begin p = {32'h0, a} * {32'h0, b};    h = p[63:32]; l = p[31:0]; end
         F_DIV: begin
            if (b == 32'h0) begin h = a; l = 32'hFFFF_FFFF; end
            else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
         end
         default: begin
            if (b == 32'h0) begin h = a; l = 32'hFFFF_FFFF; end
            else begin l = a / b; h = a % b; end
         end
      endcase
   endtask

   task automatic idle_inputs();
      valid_in = 1'b0; alu_op = 2'b00; funct = 6'h00; op_a = '0; op_b = '0;
   endtask

   // Reads HI then LO within the current cycle; caller sits at posedge+1.
   task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
      alu_op = 2'b10; valid_in = 1'b1; funct = F_MFHI;
      #1 h = mdu_res;
      funct = F_MFLO;
      #1 l = mdu_res;
      valid_in = 1'b0; funct = 6'h00;
   endtask

   // Issues one MDU op, returns edges to done (100 = timeout), leaving HI/LO settled.
   task automatic mdu_exec(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic pre_busy, output logic held);
      alu_op = 2'b10; funct = f; op_a = a; op_b = b; valid_in = 1'b1;
      #1 pre_busy = busy;
      @(posedge clk); #1;
      valid_in = 1'b0; funct = 6'h00;
      lat = 0; held = 1'b1;
      while (done !== 1'b1 && lat < 100) begin
         if (busy !== 1'b1) held = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      if (busy !== 1'b1) held = 1'b0;
      if (lat < 100) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      logic [31:0] h, l;
      reset = 1'b1; idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      reset = 1'b0;
      @(posedge clk); #1;
      read_hilo(h, l);
      vectors++; if (h !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", h); end
      vectors++; if (l !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", l); end
   endtask

   task automatic test_decode();
      logic [5:0] known [12] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                 6'b101011, F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO};
      logic [5:0] exp;
      valid_in = 1'b0;
      for (int i = 0; i < 12; i++) begin
         alu_op = 2'b10; funct = known[i];
         #1 exp = model_decode(alu_op, funct);
         vectors++;
         if ({alu_ctrl, illegal, use_mdu_res} !== exp) begin
            errors++;
            $display("FAIL decode_sweep f=%b: got %b want %b", funct, {alu_ctrl, illegal, use_mdu_res}, exp);
         end
      end
      alu_op = 2'b10; funct = 6'b000111;
      #1 vectors++;
      if ({alu_ctrl, illegal} !== 5'b11111) begin
         errors++; $display("FAIL decode_unknown: got %b want 11111", {alu_ctrl, illegal});
      end
      alu_op = 2'b00; #1 vectors++;
      if (alu_ctrl !== 4'h2 || illegal !== 1'b0) begin
         errors++; $display("FAIL decode_op00: got %h/%b want 2/0", alu_ctrl, illegal);
      end
      alu_op = 2'b01; #1 vectors++;
      if (alu_ctrl !== 4'h6 || illegal !== 1'b0) begin
         errors++; $display("FAIL decode_op01: got %h/%b want 6/0", alu_ctrl, illegal);
      end
      for (int i = 0; i < 300; i++) begin
         alu_op = 2'($urandom_range(0, 3));
         funct  = ($urandom_range(0, 1) == 1) ? known[$urandom_range(0, 11)] : 6'($urandom);
         #1 exp = model_decode(alu_op, funct);
         vectors++;
         if ({alu_ctrl, illegal, use_mdu_res} !== exp) begin
            errors++;
            $display("FAIL decode_rand op=%b f=%b: got %b want %b", alu_op, funct,
                     {alu_ctrl, illegal, use_mdu_res}, exp);
         end
      end
      idle_inputs();
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [5:0]  fs [6] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_DIV, F_DIV};
      logic [31:0] as [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'h1234_5678, 32'h8000_0000};
      logic [31:0] bs [6] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF};
      logic [31:0] eh [6] = '{32'hFFFF_FFFF, 32'h6, 32'hFFFF_FFFF, 32'd1, 32'h1234_5678, 32'h0};
      logic [31:0] el [6] = '{32'hFFFF_FFEB, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFF, 32'h8000_0000};
      logic [31:0] h, l;
      int lat;
      logic pb, held;
      for (int i = 0; i < 6; i++) begin
         mdu_exec(fs[i], as[i], bs[i], lat, pb, held);
         read_hilo(h, l);
         vectors++; if (lat != LAT) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, LAT); end
         vectors++; if (pb !== 1'b1) begin errors++; $display("FAIL dir%0d_issue_busy: got %b want 1", i, pb); end
         vectors++; if (held !== 1'b1) begin errors++; $display("FAIL dir%0d_busy_held: got %b want 1", i, held); end
         vectors++; if (h !== eh[i]) begin errors++; $display("FAIL dir%0d_hi: got %h want %h", i, h, eh[i]); end
         vectors++; if (l !== el[i]) begin errors++; $display("FAIL dir%0d_lo: got %h want %h", i, l, el[i]); end
      end
   endtask

   task automatic test_random_mdu();
      logic [5:0]  fs [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
      logic [5:0]  f;
      logic [31:0] a, b, h, l, eh, el;
      int lat;
      logic pb, held;
      for (int i = 0; i < 24; i++) begin
         f = fs[$urandom_range(0, 3)];
         a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 12)) : 32'($urandom);
         if ($urandom_range(0, 3) == 0) a = -a;
         if ($urandom_range(0, 7) == 0) b = 32'h0;
         model_mdu(f, a, b, eh, el);
         mdu_exec(f, a, b, lat, pb, held);
         read_hilo(h, l);
         vectors++;
         if (lat != LAT || h !== eh || l !== el) begin
            errors++;
            $display("FAIL rand f=%b a=%h b=%h: got lat=%0d hi=%h lo=%h want lat=%0d hi=%h lo=%h",
                     f, a, b, lat, h, l, LAT, eh, el);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] eh, el, h, l;
      int cyc;
      logic held;
      int extra;
      model_mdu(F_MULT, 32'd12345, -32'd1000, eh, el);
      alu_op = 2'b10; funct = F_MULT; op_a = 32'd12345; op_b = -32'd1000; valid_in = 1'b1;
      @(posedge clk); #1;
      held = 1'b1; cyc = 0;
      // a competing mult while busy must be ignored
      funct = F_MULT; op_a = 32'd7; op_b = 32'd9;
      repeat (3) begin
         if (busy !== 1'b1) held = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
      funct = F_MFLO; op_a = '0; op_b = '0;
      while (done !== 1'b1 && cyc < 100) begin
         if (busy !== 1'b1) held = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
      if (busy !== 1'b1) held = 1'b0;
      vectors++; if (cyc != LAT) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", cyc, LAT); end
      vectors++; if (held !== 1'b1) begin errors++; $display("FAIL b2b_stall: got %b want 1", held); end
      @(posedge clk); #1;
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_release: got %b want 0", busy); end
      vectors++; if (mdu_res !== el) begin errors++; $display("FAIL b2b_mflo: got %h want %h", mdu_res, el); end
      valid_in = 1'b0; funct = 6'h00;
      extra = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) extra++;
      end
      vectors++; if (extra != 0) begin errors++; $display("FAIL b2b_no_second_op: got %0d want 0", extra); end
      read_hilo(h, l);
      vectors++; if (h !== eh) begin errors++; $display("FAIL b2b_hi: got %h want %h", h, eh); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] h, l;
      int lat, seen;
      logic pb, held;
      alu_op = 2'b10; funct = F_DIV; op_a = 32'd100; op_b = 32'd7; valid_in = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0; funct = 6'h00;
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      vectors++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", done); end
      read_hilo(h, l);
      vectors++; if (h !== 32'h0 || l !== 32'h0) begin
         errors++; $display("FAIL rstmid_hilo: got %h/%h want 0/0", h, l);
      end
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen++;
      end
      vectors++; if (seen != 0) begin errors++; $display("FAIL rstmid_stray_done: got %0d want 0", seen); end
      mdu_exec(F_MULTU, 32'd5, 32'd6, lat, pb, held);
      read_hilo(h, l);
      vectors++; if (lat != LAT) begin errors++; $display("FAIL rstmid_fresh_latency: got %0d want %0d", lat, LAT); end
      vectors++; if (l !== 32'd30 || h !== 32'd0) begin
         errors++; $display("FAIL rstmid_fresh_result: got %h/%h want 0/1e", h, l);
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_decode();
      test_directed();
      test_random_mdu();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_ctrl_mdu.md
Name: alu_ctrl_mdu

Overview:
Next-generation ALU control for the SCPU datapath. Decodes ALUOp/Funct into the 4-bit ALU control code as before. Adds an iterative multiply/divide unit with HI/LO registers and a busy/done handshake, so the same control point also covers mult/multu/div/divu/mfhi/mflo. Sits between the main control unit and the ALU. `busy` drives the PC/IF stall.

Parameters:
WIDTH, 32, operand/result width; HI and LO are WIDTH bits each.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous active-high reset.
alu_op  in  2  from main control: 00 lw/sw/addi, 01 beq, 10 R-type, 11 reserved.
funct  in  6  instruction[5:0].
valid_in  in  1  instruction in this stage is live this cycle.
op_a  in  WIDTH  rs value.
op_b  in  WIDTH  rt value.
alu_ctrl  out  4  code to ALU (ALU_ADD/SUB/AND/OR/SLT/SLTU/NOP).
use_mdu_res  out  1  writeback selects mdu_res instead of ALU result.
mdu_res  out  WIDTH  HI (mfhi) or LO (mflo).
busy  out  1  MDU operation in flight; upstream must stall.
done  out  1  one-cycle pulse when HI/LO update.
illegal  out  1  alu_op=10 with unknown funct, or alu_op=11.

Behaviour:
- Reset (sync, high): state IDLE; HI=LO=0; counter=0; busy=0; done=0. Reset overrides an in-flight operation: the result is discarded and HI/LO are cleared.
- Decode is combinational with no latency:
  - 00 -> ADD. 01 -> SUB.
  - 10 -> funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 101011 SLTU.
  - 11 or unknown funct -> alu_ctrl=NOP, illegal=1.
  - MDU functs set alu_ctrl=NOP, illegal=0:
    - mult 011000, multu 011001, div 011010, divu 011011.
    - mfhi 010000, mflo 010010.
- use_mdu_res=1 only for mfhi/mflo. mdu_res = HI or LO register value, combinational.
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE: valid_in & mult/multu -> latch operands, counter=WIDTH, go to MUL. div/divu -> go to DIV. Signed ops convert both operands to magnitude and record result signs.
  - MUL: shift-add, one bit per cycle over a 2*WIDTH accumulator. Counter decrements; at counter==1 go to FIN.
  - DIV: restoring divide, one bit per cycle; exits to FIN the same way.
  - FIN: apply sign correction. Write HI/LO (mult: HI=upper, LO=lower; div: LO=quotient, HI=remainder). done=1 for this cycle. Go to IDLE.
- Latency: start cycle + WIDTH iteration cycles + FIN = WIDTH+2 cycles from accept to HI/LO valid. HI/LO are readable the cycle after done.
- busy=1 from the cycle after accept through the FIN cycle inclusive. busy is also asserted combinationally in IDLE when valid_in carries an MDU op, so the issuing instruction holds one extra cycle.
- While busy, valid_in is ignored; no new op is accepted.
- mfhi/mflo issued while busy: busy stays high; the stalled reader sees the final value.
- Sign rules:
  - Signed div: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Most negative / -1: LO = most negative, HI = 0. No trap.
- Divide by zero (either signedness): HI = op_a, LO = all ones. Full WIDTH+2 latency; no flag.
- mult by zero: still takes full latency; no early exit.
- HI/LO change only in FIN or on reset.

Decomposition:
- Shared package/include (extend ctrl_encode_def.v): ALU_* codes including ALU_NOP; funct_* codes including the six MDU functs; MDU FSM state encodings.
- One natural sub-module: mdu_iter. It holds the shift-add/restoring datapath and counter, with start/op/signed inputs and hi/lo/done outputs. The top keeps the decode and the busy logic.

Test Plan:
- R-type sweep: alu_op=10 with each funct -> alu_ctrl matches the ALU_* code. funct=000111 -> NOP, illegal=1. alu_op=00 -> ADD; alu_op=01 -> SUB.
- mult: a=-3 (0xFFFFFFFD), b=7 -> done at cycle 34 after accept; HI=0xFFFFFFFF, LO=0xFFFFFFEB. multu with the same operands -> HI=0x00000006, LO=0xFFFFFFEB.
- div: a=-7, b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu a=7, b=2 -> LO=3, HI=1.
- Divide by zero: div a=0x12345678, b=0 -> HI=0x12345678, LO=0xFFFFFFFF, latency 34. Also 0x80000000 / -1 -> LO=0x80000000, HI=0.
- Stall/hazard: mflo issued the cycle after mult accept -> busy held until done. mdu_res equals the new LO in the cycle after done. A second mult presented during busy is not accepted.
- Reset at iteration 10 of a div -> next cycle state IDLE, busy=0, HI=LO=0, no done pulse. Then a fresh multu 5*6 -> LO=30.
